count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the count value, limit and count output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to (re)start a count run.
REQ-005 stop  input  1  abort the run and return to idle.
REQ-006 pause  input  1  level; while high, freezes a running count.
REQ-007 periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot.
REQ-008 limit  input  WIDTH  terminal count value, sampled on accepted start.
REQ-009 count  output  WIDTH  current count value (registered).
REQ-010 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  registered one-cycle pulse at terminal count.

Function
REQ-013 The block SHALL hold an internal limit_q register; it loads limit on every accepted start and ignores limit at all other times.
REQ-014 Input priority per cycle SHALL be stop > start > pause.
REQ-015 stop in any state SHALL, at the next edge: state IDLE, count 0, done 0.
REQ-016 start (no stop) in any state SHALL, at the next edge: state RUN, count 0, limit_q <= limit; pause that cycle is ignored.
REQ-017 In RUN with count != limit_q and pause low, count SHALL increment by 1 per edge.
REQ-018 In RUN with count == limit_q and pause low: done SHALL be 1 for the following cycle; if periodic=1, count <= 0 and state stays RUN; if periodic=0, state <= DONE and count holds limit_q.
REQ-019 periodic SHALL be sampled at the terminal edge, not at start.
REQ-020 In RUN with pause high, the block SHALL enter PAUSE at the next edge with count unchanged, even if count == limit_q.
REQ-021 In PAUSE, count SHALL hold; pause low SHALL return to RUN at the next edge, resuming from the held count.
REQ-022 In DONE, count SHALL hold limit_q until start or stop; pause has no effect in IDLE or DONE.
REQ-023 limit = 0 SHALL be legal: the terminal event occurs at the first RUN edge after start (done asserted two cycles after start is sampled).
REQ-024 count SHALL never exceed limit_q; no WIDTH wrap-around is possible.
REQ-025 done SHALL be 0 on every cycle other than the one following a terminal event.
REQ-026 Run length from start to done SHALL be limit_q+1 RUN edges plus any PAUSE cycles.

Reset
REQ-027 While rst_n is low, without waiting for clk: state IDLE, count 0, limit_q 0, done 0, busy 0.
REQ-028 Reset asserted mid-run SHALL abort immediately; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro COUNT_SEQUENCER_IRQ_EN, when defined, SHALL add input irq_clr (1 bit) and output irq (1 bit, reset 0).
REQ-030 With the macro defined, irq SHALL set on the edge that asserts done, stay set until irq_clr is sampled high, and set SHALL win over a simultaneous clear.
REQ-031 Without the macro, irq and irq_clr SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 One-shot: reset, limit=3, periodic=0, start 1 cycle -> count 0,1,2,3; done pulses once; state DONE; count holds 3.
REQ-033 Periodic: limit=2, periodic=1, start -> count 0,1,2,0,1,2...; done one cycle after each 2; busy stays 1.
REQ-034 Pause/stop: limit=10, start; pause high 4 cycles at count=5 -> count holds 5 in PAUSE, then resumes 6; stop at count=8 -> IDLE, count 0, no done.
REQ-035 Priority and limit: start+stop same cycle -> IDLE; limit=0 start -> done after 2 cycles; change limit mid-run from 5 to 1 -> run still terminates at 5.
REQ-036 Reset mid-run: assert rst_n=0 asynchronously at count=4 -> outputs zero before next clk edge; IRQ_EN build: done sets irq, irq_clr clears it, coincident done+irq_clr leaves irq=1.

Source files
------------

// File: rtl/count_sequencer.sv
// Start/stop/pause count sequencer: counts 0..limit_q, then reloads (periodic) or parks in DONE.
// Optional interrupt output enabled by defining COUNT_SEQUENCER_IRQ_EN (adds irq_clr / irq).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start, count held at 0
// ST_RUN   | counting one step per edge toward limit_q
// ST_PAUSE | count frozen while pause is high
// ST_DONE  | one-shot finished, count holds limit_q until start/stop
module count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
`ifdef COUNT_SEQUENCER_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

  // Priority: stop, then start, then pause/normal sequencing.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = ST_RUN;
      count_d = '0;
      limit_d = limit;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (count_q == limit_q) begin
            done_d = 1'b1;
            if (periodic) count_d = '0;
            else          state_d = ST_DONE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef COUNT_SEQUENCER_IRQ_EN
  logic irq_q;

  // A new terminal event outranks a coincident clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_q <= 1'b0;
    else if (done_d)  irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

  assign count = count_q;
  assign state = state_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; define COUNT_SEQUENCER_IRQ_EN to also exercise irq.
module tb_count_sequencer;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] limit = 8'd0;
  logic [7:0] count;
  logic [1:0] state;
  logic       busy;
  logic       done;
`ifdef COUNT_SEQUENCER_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .limit    (limit),
`ifdef COUNT_SEQUENCER_IRQ_EN
    .irq_clr  (irq_clr),
    .irq      (irq),
`endif
    .count    (count),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, count, busy, done} !== {S_IDLE, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got st=%b cnt=%0d busy=%b done=%b want st=00 cnt=0 busy=0 done=0", state, count, busy, done);
    end
`ifdef COUNT_SEQUENCER_IRQ_EN
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({state, count} !== {S_IDLE, 8'd0}) begin
      errors++;
      $display("FAIL reset_release_idle got st=%b cnt=%0d want st=00 cnt=0", state, count);
    end
  endtask

  task automatic test_one_shot();
    limit = 8'd3; periodic = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({state, count, busy, done} !== {S_RUN, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL one_shot_start got st=%b cnt=%0d busy=%b done=%b want st=01 cnt=0 busy=1 done=0", state, count, busy, done);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if ({state, count, done} !== {S_RUN, 8'(i), 1'b0}) begin
        errors++;
        $display("FAIL one_shot_count got st=%b cnt=%0d done=%b want st=01 cnt=%0d done=0", state, count, done, i);
      end
    end
    tick();
    vectors++;
    if ({state, count, busy, done} !== {S_DONE, 8'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL one_shot_terminal got st=%b cnt=%0d busy=%b done=%b want st=11 cnt=3 busy=0 done=1", state, count, busy, done);
    end
    pause = 1'b1;
    tick();
    tick();
    pause = 1'b0;
    vectors++;
    if ({state, count, done} !== {S_DONE, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL one_shot_hold got st=%b cnt=%0d done=%b want st=11 cnt=3 done=0", state, count, done);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp_cnt [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
    logic       exp_done[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    limit = 8'd2; periodic = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({state, count, busy, done} !== {S_RUN, exp_cnt[i], 1'b1, exp_done[i]}) begin
        errors++;
        $display("FAIL periodic_step%0d got st=%b cnt=%0d busy=%b done=%b want st=01 cnt=%0d busy=1 done=%b",
                 i, state, count, busy, done, exp_cnt[i], exp_done[i]);
      end
    end
    periodic = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if ({state, count, busy} !== {S_IDLE, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL periodic_stop got st=%b cnt=%0d busy=%b want st=00 cnt=0 busy=0", state, count, busy);
    end
  endtask

  task automatic test_pause_stop();
    limit = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({state, count, busy, done} !== {S_PAUSE, 8'd5, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL pause_hold%0d got st=%b cnt=%0d busy=%b done=%b want st=10 cnt=5 busy=1 done=0", i, state, count, busy, done);
      end
    end
    pause = 1'b0;
    tick();
    vectors++;
    if ({state, count} !== {S_RUN, 8'd5}) begin
      errors++;
      $display("FAIL pause_resume got st=%b cnt=%0d want st=01 cnt=5", state, count);
    end
    tick();
    vectors++;
    if (count !== 8'd6) begin errors++; $display("FAIL pause_next got cnt=%0d want 6", count); end
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if ({state, count, busy, done} !== {S_IDLE, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_abort got st=%b cnt=%0d busy=%b done=%b want st=00 cnt=0 busy=0 done=0", state, count, busy, done);
    end
  endtask

  task automatic test_priority_limit();
    limit = 8'd4; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    vectors++;
    if ({state, count} !== {S_IDLE, 8'd0}) begin
      errors++;
      $display("FAIL start_stop_prio got st=%b cnt=%0d want st=00 cnt=0", state, count);
    end
    limit = 8'd0; start = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0; pause = 1'b0;
    vectors++;
    if ({state, count, done} !== {S_RUN, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL limit0_start got st=%b cnt=%0d done=%b want st=01 cnt=0 done=0", state, count, done);
    end
    tick();
    vectors++;
    if ({state, count, done} !== {S_DONE, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL limit0_done got st=%b cnt=%0d done=%b want st=11 cnt=0 done=1", state, count, done);
    end
    limit = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; limit = 8'd1;
    repeat (5) tick();
    vectors++;
    if ({state, count, done} !== {S_RUN, 8'd5, 1'b0}) begin
      errors++;
      $display("FAIL limit_change_run got st=%b cnt=%0d done=%b want st=01 cnt=5 done=0", state, count, done);
    end
    tick();
    vectors++;
    if ({state, count, done} !== {S_DONE, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL limit_change_term got st=%b cnt=%0d done=%b want st=11 cnt=5 done=1", state, count, done);
    end
  endtask

  task automatic test_pause_at_terminal();
    limit = 8'd2; periodic = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; periodic = 1'b1;
    repeat (2) tick();
    pause = 1'b1;
    tick();
    vectors++;
    if ({state, count, done} !== {S_PAUSE, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL term_pause got st=%b cnt=%0d done=%b want st=10 cnt=2 done=0", state, count, done);
    end
    pause = 1'b0;
    tick();
    tick();
    vectors++;
    if ({state, count, done} !== {S_RUN, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL late_periodic got st=%b cnt=%0d done=%b want st=01 cnt=0 done=1", state, count, done);
    end
    periodic = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    limit = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (count !== 8'd4) begin errors++; $display("FAIL midrun_pre got cnt=%0d want 4", count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, count, busy, done} !== {S_IDLE, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_async got st=%b cnt=%0d busy=%b done=%b want st=00 cnt=0 busy=0 done=0", state, count, busy, done);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({state, count} !== {S_IDLE, 8'd0}) begin
      errors++;
      $display("FAIL midrun_wait got st=%b cnt=%0d want st=00 cnt=0", state, count);
    end
  endtask

`ifdef COUNT_SEQUENCER_IRQ_EN
  task automatic test_irq();
    limit = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
    tick();
    vectors++;
    if ({done, irq} !== 2'b11) begin errors++; $display("FAIL irq_set got done=%b irq=%b want 1 1", done, irq); end
    tick();
    vectors++;
    if ({done, irq} !== 2'b01) begin errors++; $display("FAIL irq_sticky got done=%b irq=%b want 0 1", done, irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    vectors++;
    if ({done, irq} !== 2'b11) begin errors++; $display("FAIL irq_set_wins got done=%b irq=%b want 1 1", done, irq); end
    tick();
    vectors++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_race got %b want 1", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause_stop();
    test_priority_limit();
    test_pause_at_terminal();
    test_reset_midrun();
`ifdef COUNT_SEQUENCER_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
